// File: rtl/enemy_fire_scheduler_pkg.sv
// Shared game constants for the enemy fire scheduler: enemy count, coordinate
// width, FSM state encodings and the 8-bit LFSR seed/taps.
package enemy_fire_scheduler_pkg;

   localparam int N_INIMIGOS = 5;
   localparam int COORD_W    = 10;
   localparam int IDX_W      = 3;

   localparam logic [1:0] ST_COOLDOWN = 2'd0;
   localparam logic [1:0] ST_SELECT   = 2'd1;
   localparam logic [1:0] ST_REQUEST  = 2'd2;

   // Taps 8,6,5,4 map to bits 7,5,4,3 of the shift register.
   localparam logic [7:0] LFSR_SEED = 8'h01;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/enemy_fire_scheduler_if.sv
// Shot request handshake between the scheduler and the entities datapath,
// together with the per-enemy eligibility vectors the datapath publishes.
interface enemy_fire_scheduler_if #(
   parameter int N = 5
);
   logic         fire_req;
   logic         fire_ack;
   logic [2:0]   fire_idx;
   logic [N-1:0] inimigo_vivo;
   logic [N-1:0] slot_livre;

   modport master (
      output fire_req,
      output fire_idx,
      input  fire_ack,
      input  inimigo_vivo,
      input  slot_livre
   );

   modport slave (
      input  fire_req,
      input  fire_idx,
      output fire_ack,
      output inimigo_vivo,
      output slot_livre
   );
endinterface

// File: rtl/enemy_fire_scheduler_rr_pick.sv
// Combinational round-robin search: first set bit of mask at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
   parameter int N = 5
) (
   input  logic [N-1:0] mask,
   input  logic [2:0]   ptr,
   output logic         valid,
   output logic [2:0]   idx
);

   function automatic logic [2:0] wrap_add(input logic [2:0] p, input int k);
      int j;
      j = int'(p) + k;
      if (j >= N) j = j - N;
      return 3'(j);
   endfunction

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      // Walk offsets from farthest to nearest so the nearest hit is written last.
      for (int k = N - 1; k >= 0; k--) begin
         if (mask[wrap_add(ptr, k)]) begin
            valid = 1'b1;
            idx   = wrap_add(ptr, k);
         end
      end
   end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: randomised per-frame cooldown, round-robin choice of an
// eligible enemy, then a held request until the datapath acknowledges it.
module enemy_fire_scheduler #(
   parameter int N_INIMIGOS    = enemy_fire_scheduler_pkg::N_INIMIGOS,
   parameter int COOLDOWN_BASE = 30,
   parameter int JITTER_BITS   = 4
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic                   pausa,
   enemy_fire_scheduler_if.master fire,
   output logic                   cooldown_ativo
);
   import enemy_fire_scheduler_pkg::*;

   localparam int CNT_W = $clog2(COOLDOWN_BASE + 2**JITTER_BITS);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_load;
   logic [2:0]       rr_ptr;
   logic [2:0]       fire_idx_q;
   logic [7:0]       lfsr;

   logic [N_INIMIGOS-1:0] eligible;
   logic                  pick_valid;
   logic [2:0]            pick_idx;
   logic                  idx_ok;

   assign eligible = fire.inimigo_vivo & fire.slot_livre;
   assign idx_ok   = fire.inimigo_vivo[fire_idx_q] && fire.slot_livre[fire_idx_q];
   assign cnt_load = CNT_W'(COOLDOWN_BASE) + CNT_W'(lfsr[JITTER_BITS-1:0]);

   rr_pick #(.N(N_INIMIGOS)) u_rr_pick (
      .mask  (eligible),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // NOTE: registered state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state      <= ST_COOLDOWN;
         cnt        <= CNT_W'(COOLDOWN_BASE);
         rr_ptr     <= '0;
         fire_idx_q <= '0;
         lfsr       <= LFSR_SEED;
      end else if (!pausa) begin
         if (frame_tick) lfsr <= lfsr_next(lfsr);
         case (state)
            ST_COOLDOWN: begin
               if (cnt == '0)      state <= ST_SELECT;
               else if (frame_tick) cnt  <= cnt - 1'b1;
            end
            ST_SELECT: begin
               if (pick_valid) begin
                  fire_idx_q <= pick_idx;
                  rr_ptr     <= (pick_idx == 3'(N_INIMIGOS - 1)) ? 3'd0 : pick_idx + 3'd1;
                  state      <= ST_REQUEST;
               end
            end
            ST_REQUEST: begin
               // An ack in the same cycle as the target going ineligible still grants.
               if (fire.fire_ack) begin
                  state <= ST_COOLDOWN;
                  cnt   <= cnt_load;
               end else if (!idx_ok) begin
                  state <= ST_SELECT;
               end
            end
            default: state <= ST_COOLDOWN;
         endcase
      end
   end

   assign fire.fire_req  = (state == ST_REQUEST);
   assign fire.fire_idx  = fire_idx_q;
   assign cooldown_ativo = (state == ST_COOLDOWN);

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler: cooldown length, round-robin order,
// withdrawal, pause and asynchronous reset behaviour.
module tb_enemy_fire_scheduler;
   import enemy_fire_scheduler_pkg::*;

   logic CLOCK_50 = 1'b0;
   logic reset;
   logic frame_tick;
   logic pausa;
   logic cooldown_ativo;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [7:0] lfsr_m;
   int         exp_cd;

   enemy_fire_scheduler_if #(.N(5)) fire_bus ();

   enemy_fire_scheduler #(
      .N_INIMIGOS    (5),
      .COOLDOWN_BASE (30),
      .JITTER_BITS   (4)
   ) dut (
      .CLOCK_50       (CLOCK_50),
      .reset          (reset),
      .frame_tick     (frame_tick),
      .pausa          (pausa),
      .fire           (fire_bus.master),
      .cooldown_ativo (cooldown_ativo)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (!pausa) lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   endtask

   // Ticks frames until fire_req rises; checks tick count and chosen index.
   task automatic wait_req(input string tag, input int exp_ticks, input logic [2:0] exp_idx);
      int n = 0;
      while (!fire_bus.fire_req && n < 200) begin
         tick();
         n++;
         repeat (3) step();
      end
      check_eq({tag, "_ticks"}, n, exp_ticks);
      check_eq({tag, "_idx"}, {29'd0, fire_bus.fire_idx}, {29'd0, exp_idx});
   endtask

   task automatic grant(input string tag);
      exp_cd = 30 + int'(lfsr_m[3:0]);
      fire_bus.fire_ack = 1'b1;
      step();
      fire_bus.fire_ack = 1'b0;
      check_eq({tag, "_req_low"}, {31'd0, fire_bus.fire_req}, 0);
      check_eq({tag, "_cd"}, {31'd0, cooldown_ativo}, 1);
   endtask

   initial begin
      reset                 = 1'b0;
      frame_tick            = 1'b0;
      pausa                 = 1'b0;
      fire_bus.fire_ack     = 1'b0;
      fire_bus.inimigo_vivo = 5'b11111;
      fire_bus.slot_livre   = 5'b11111;
      lfsr_m                = 8'h01;
      #1;
      check_eq("rst_req", {31'd0, fire_bus.fire_req}, 0);
      check_eq("rst_idx", {29'd0, fire_bus.fire_idx}, 0);
      check_eq("rst_cd", {31'd0, cooldown_ativo}, 1);
      step();
      step();
      reset = 1'b1;

      // First request after exactly COOLDOWN_BASE ticks, then 0,1,2 in order.
      wait_req("first", 30, 3'd0);
      grant("g0");
      wait_req("rr1", exp_cd, 3'd1);
      grant("g1");
      wait_req("rr2", exp_cd, 3'd2);
      grant("g2");

      // Only enemies 2 and 4 alive with rr_ptr=3.
      fire_bus.inimigo_vivo = 5'b10100;
      wait_req("sparse4", exp_cd, 3'd4);
      grant("g4s");
      wait_req("sparse2", exp_cd, 3'd2);
      grant("g2s");

      // Wrap from index 4 back to 0.
      fire_bus.inimigo_vivo = 5'b11111;
      wait_req("rr3", exp_cd, 3'd3);
      grant("g3");
      wait_req("rr4", exp_cd, 3'd4);
      grant("g4");
      wait_req("wrap0", exp_cd, 3'd0);
      grant("g0w");

      // Slot 1 goes busy while requested: withdraw, then reselect 2.
      wait_req("pre_drop", exp_cd, 3'd1);
      fire_bus.slot_livre = 5'b11101;
      step();
      check_eq("drop_req_low", {31'd0, fire_bus.fire_req}, 0);
      check_eq("drop_no_cd", {31'd0, cooldown_ativo}, 0);
      step();
      check_eq("reselect_req", {31'd0, fire_bus.fire_req}, 1);
      check_eq("reselect_idx", {29'd0, fire_bus.fire_idx}, 2);
      grant("g2d");
      fire_bus.slot_livre = 5'b11111;

      // Slot drop coincident with ack: the grant wins.
      wait_req("pre_coinc", exp_cd, 3'd3);
      fire_bus.slot_livre = 5'b10111;
      grant("coinc");
      fire_bus.slot_livre = 5'b11111;

      // Pause mid-cooldown at count 10 with 100 dropped ticks.
      for (int i = 0; i < exp_cd - 10; i++) tick();
      pausa = 1'b1;
      for (int i = 0; i < 100; i++) tick();
      check_eq("pause_cd", {31'd0, cooldown_ativo}, 1);
      check_eq("pause_req", {31'd0, fire_bus.fire_req}, 0);
      pausa = 1'b0;
      wait_req("after_pause", 10, 3'd4);

      // Pause in REQUEST holds fire_req and ignores ack.
      pausa = 1'b1;
      fire_bus.fire_ack = 1'b1;
      repeat (5) step();
      check_eq("pause_hold_req", {31'd0, fire_bus.fire_req}, 1);
      check_eq("pause_hold_idx", {29'd0, fire_bus.fire_idx}, 4);
      fire_bus.fire_ack = 1'b0;
      pausa = 1'b0;
      grant("g4p");

      // Asynchronous reset during REQUEST for index 1.
      wait_req("rr0b", exp_cd, 3'd0);
      grant("g0b");
      wait_req("pre_rst", exp_cd, 3'd1);
      reset = 1'b0;
      #1;
      check_eq("arst_req", {31'd0, fire_bus.fire_req}, 0);
      check_eq("arst_idx", {29'd0, fire_bus.fire_idx}, 0);
      check_eq("arst_cd", {31'd0, cooldown_ativo}, 1);
      step();
      reset = 1'b1;
      lfsr_m = 8'h01;
      wait_req("post_rst", 30, 3'd0);
      grant("g0r");

      // No enemies alive: no requests, and stray acks are ignored.
      fire_bus.inimigo_vivo = 5'b00000;
      fire_bus.fire_ack = 1'b1;
      for (int i = 0; i < exp_cd; i++) tick();
      repeat (3) step();
      check_eq("none_cd", {31'd0, cooldown_ativo}, 0);
      check_eq("none_req", {31'd0, fire_bus.fire_req}, 0);
      repeat (20) step();
      check_eq("none_req_late", {31'd0, fire_bus.fire_req}, 0);
      fire_bus.fire_ack = 1'b0;
      fire_bus.inimigo_vivo = 5'b11111;
      step();
      check_eq("revive_req", {31'd0, fire_bus.fire_req}, 1);
      check_eq("revive_idx", {29'd0, fire_bus.fire_idx}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 The block SHALL have the parameter N_INIMIGOS, default 5, meaning the number of enemies and enemy-shot slots (slot i belongs to enemy i).
REQ-002 The block SHALL have the parameter COOLDOWN_BASE, default 30, meaning the minimum number of frames between shot grants.
REQ-003 The block SHALL have the parameter JITTER_BITS, default 4, meaning the width of the random extra cooldown (0..2^JITTER_BITS-1 frames).
REQ-004 The block SHALL have the port CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have the port frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 The block SHALL have the port pausa  input  1  high freezes all counters, pointer and LFSR.
REQ-008 The block SHALL have the port inimigo_vivo  input  N_INIMIGOS  bit i high = enemy i alive.
REQ-009 The block SHALL have the port slot_livre  input  N_INIMIGOS  bit i high = shot slot i unused.
REQ-010 The block SHALL have the port fire_ack  input  1  entities datapath accepted the current request.
REQ-011 The block SHALL have the port fire_req  output  1  request to spawn a shot.
REQ-012 The block SHALL have the port fire_idx  output  3  enemy index for the request.
REQ-013 The block SHALL have the port cooldown_ativo  output  1  high while in COOLDOWN.

Function
REQ-014 The FSM SHALL have exactly three states: COOLDOWN, SELECT and REQUEST.
REQ-015 COOLDOWN SHALL decrement the frame counter by one on each frame_tick while pausa is low; at count 0 the FSM SHALL move to SELECT on the next cycle.
REQ-016 On entry to COOLDOWN, the counter SHALL load COOLDOWN_BASE plus the low JITTER_BITS bits of the LFSR, sized to hold the maximum sum without overflow.
REQ-017 The LFSR SHALL be 8-bit maximal-length (taps 8,6,5,4), SHALL advance once per frame_tick when not paused, and SHALL be seeded to 8'h01; the all-zero state is unreachable.
REQ-018 SELECT SHALL, in one cycle, choose the first index i, searching round-robin from rr_ptr upward with wrap at N_INIMIGOS-1 to 0, for which inimigo_vivo[i] and slot_livre[i] are both high.
REQ-019 If a candidate exists, SELECT SHALL latch fire_idx, go to REQUEST and set rr_ptr to idx+1 mod N_INIMIGOS.
REQ-020 If no candidate exists, SELECT SHALL remain in SELECT, re-evaluating every cycle, and rr_ptr SHALL stay unchanged.
REQ-021 fire_req SHALL be high exactly in REQUEST, and fire_idx SHALL be stable while fire_req is high.
REQ-022 A grant SHALL occur on any cycle with fire_req and fire_ack both high; the FSM SHALL then enter COOLDOWN on the next cycle.
REQ-023 fire_ack while fire_req is low SHALL be ignored.
REQ-024 If, in REQUEST, enemy fire_idx dies or its slot becomes busy before ack, fire_req SHALL drop the next cycle and the FSM SHALL return to SELECT without moving rr_ptr, unless ack arrives the same cycle, in which case the grant wins.
REQ-025 While pausa is high, state, counter, rr_ptr, LFSR and fire_req SHALL hold their values.
REQ-026 A frame_tick coincident with pausa SHALL be dropped.
REQ-027 When inimigo_vivo is all zero, the block SHALL issue no requests.

Reset
REQ-028 Asserting reset low SHALL immediately, at any point including mid-REQUEST, force: state = COOLDOWN, counter = COOLDOWN_BASE, rr_ptr = 0, LFSR = 8'h01, fire_req = 0, fire_idx = 0, cooldown_ativo = 1.
REQ-029 After reset deassertion, the first request SHALL NOT precede COOLDOWN_BASE frame_ticks.

Structure
REQ-030 A shared game package SHALL hold N_INIMIGOS, the coordinate width (10), the state enum and the LFSR seed and tap constants.
REQ-031 A single sub-module, rr_pick, SHALL implement the combinational round-robin first-set search (mask, pointer -> valid, index).
REQ-032 All other logic SHALL reside in enemy_fire_scheduler; no multicycle paths are allowed.

Verification
REQ-033 Reset release, all alive, all slots free, COOLDOWN_BASE=30 -> fire_req rises after 30..45 frame_ticks with fire_idx=0; ack -> fire_req low next cycle, cooldown_ativo=1.
REQ-034 Three consecutive grants with immediate ack, all eligible -> fire_idx sequence 0, 1, 2; after index 4 the next grant is 0.
REQ-035 inimigo_vivo=5'b10100 (enemies 2 and 4), slots free, rr_ptr=3 -> fire_idx=4, then 2.
REQ-036 In REQUEST with fire_idx=1, slot_livre[1] drops with no ack -> fire_req low next cycle, re-selects 2 if eligible; the same drop coincident with ack -> grant counted, COOLDOWN entered.
REQ-037 pausa=1 for 100 frame_ticks mid-COOLDOWN at count 10 -> counter still 10 on release; pausa during REQUEST holds fire_req=1.
REQ-038 reset pulsed low for one cycle during REQUEST -> fire_req=0 asynchronously, and all outputs match the reset values in REQ-028.
